// File: rtl/cla32_arb_pkg.sv
// Shared types and sizes for the CLA32 arbiter slice.
package cla32_arb_pkg;
   localparam int WORD_W  = 32;
   localparam int MAX_REQ = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;
endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with group generate/propagate
// chained across the eight groups.
module CLA32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] sum,
   output logic        c_out
);
   logic [31:0] p;
   logic [31:0] g;
   logic [7:0]  grp_g;
   logic [7:0]  grp_p;
   logic [8:0]  grp_c;

   assign p = a ^ b;
   assign g = a & b;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_grp
         localparam int B = 4 * gi;
         logic c1, c2, c3;
         assign c1 = g[B] | (p[B] & grp_c[gi]);
         assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
         assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                   | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
         assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
         assign grp_p[gi] = &p[B+3:B];
         assign sum[B+3:B] = p[B+3:B] ^ {c3, c2, c1, grp_c[gi]};
      end
   endgenerate

   // Group-level lookahead evaluated procedurally so the carry vector has no self-loop.
   always_comb begin
      grp_c[0] = c_in;
      for (int k = 0; k < 8; k++) begin
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
   end

   assign c_out = grp_c[8];
endmodule

// File: rtl/cla32_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester at or after rr_ptr, with wrap.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid
);
   always_comb begin
      logic [ID_W:0] idx;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      idx       = '0;
      // Walk from the farthest offset down so the nearest valid index wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ)) begin
            idx = idx - (ID_W+1)'(NUM_REQ);
         end
         if (req_valid[idx[ID_W-1:0]]) begin
            gnt_id    = idx[ID_W-1:0];
            gnt_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cla32_arbiter.sv
// Round-robin sequencer sharing one CLA32 among NUM_REQ requesters with multi-word carry chaining.
// Optional subtract support is enabled by defining CLA32_ARB_SUB_EN.
module cla32_arbiter
   import cla32_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*WORD_W-1:0] req_a,
   input  logic [NUM_REQ*WORD_W-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_cin,
   input  logic [NUM_REQ-1:0]        req_sub,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [WORD_W-1:0]         rsp_sum,
   output logic                      rsp_cout,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      rsp_last
);
   arb_state_e        state_reg, state_next;
   logic [ID_W-1:0]   rr_ptr, lock_id, pick_id, gnt_id, ptr_next;
   logic              pick_valid, gnt_valid, out_free, accept, first_word, last_sel;
   logic              carry_q, cin_eff, c_out_w;
   logic [WORD_W-1:0] a_sel, b_sel, b_eff, sum_w;

   rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .gnt_id    (pick_id),
      .gnt_valid (pick_valid)
   );

   assign first_word = (state_reg == IDLE);
   assign gnt_id     = first_word ? pick_id : lock_id;
   assign gnt_valid  = first_word ? pick_valid : req_valid[lock_id];
   assign out_free   = !rsp_valid || rsp_ready;
   assign accept     = rst_n && gnt_valid && out_free;
   assign a_sel      = req_a[gnt_id*WORD_W +: WORD_W];
   assign b_sel      = req_b[gnt_id*WORD_W +: WORD_W];
   assign last_sel   = req_last[gnt_id];
   assign ptr_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

`ifdef CLA32_ARB_SUB_EN
   logic sub_q, sub_eff;
   assign sub_eff = first_word ? req_sub[gnt_id] : sub_q;
   assign b_eff   = sub_eff ? ~b_sel : b_sel;
   // A subtracting first word forces carry-in to 1 (two's complement), overriding req_cin.
   assign cin_eff = first_word ? (req_sub[gnt_id] | req_cin[gnt_id]) : carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= 1'b0;
      end else if (accept && first_word) begin
         sub_q <= req_sub[gnt_id];
      end
   end
`else
   logic unused_sub;
   assign unused_sub = ^req_sub;
   assign b_eff      = b_sel;
   assign cin_eff    = first_word ? req_cin[gnt_id] : carry_q;
`endif

   CLA32 u_cla (
      .a     (a_sel),
      .b     (b_eff),
      .c_in  (cin_eff),
      .sum   (sum_w),
      .c_out (c_out_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (accept) begin
         if (first_word && !last_sel) begin
            state_next = BUSY;
         end else if (!first_word && last_sel) begin
            state_next = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         carry_q   <= 1'b0;
         lock_id   <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= '0;
         rsp_last  <= 1'b0;
      end else if (accept) begin
         carry_q   <= c_out_w;
         rsp_valid <= 1'b1;
         rsp_sum   <= sum_w;
         rsp_cout  <= c_out_w;
         rsp_id    <= gnt_id;
         rsp_last  <= last_sel;
         if (last_sel) begin
            rr_ptr <= ptr_next;
         end
         if (first_word && !last_sel) begin
            lock_id <= gnt_id;
         end
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule
